// File: rtl/qsys_host_mailbox.sv
// Host mailbox: an Avalon-MM register slave with a host-to-fabric TX stream FIFO, a
// fabric-to-host RX stream FIFO, a scratch register and a masked level interrupt.
module qsys_host_mailbox #(
  parameter int unsigned FIFO_AW = 3
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset_n,
  input  logic [2:0]  avs_S1_address,
  input  logic        avs_S1_read,
  input  logic        avs_S1_write,
  input  logic [31:0] avs_S1_writedata,
  input  logic [3:0]  avs_S1_byteenable,
  output logic [31:0] avs_S1_readdata,
  output logic        avs_S1_readdatavalid,
  output logic        avs_S1_waitrequest,
  output logic [31:0] aso_TX_data,
  output logic        aso_TX_valid,
  input  logic        aso_TX_ready,
  input  logic [31:0] asi_RX_data,
  input  logic        asi_RX_valid,
  output logic        asi_RX_ready,
  output logic        ins_IRQ_irq
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;

  localparam logic [2:0] AddrStatus  = 3'd0;
  localparam logic [2:0] AddrPend    = 3'd1;
  localparam logic [2:0] AddrMask    = 3'd2;
  localparam logic [2:0] AddrTxData  = 3'd3;
  localparam logic [2:0] AddrRxData  = 3'd4;
  localparam logic [2:0] AddrScratch = 3'd5;

  logic [31:0]        tx_mem [Depth];
  logic [FIFO_AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [LW-1:0]      tx_level_q;
  logic [31:0]        rx_mem [Depth];
  logic [FIFO_AW-1:0] rx_wptr_q, rx_rptr_q;
  logic [LW-1:0]      rx_level_q;

  logic [2:0]  pend_q, mask_q, pend_d, pend_set, pend_clr;
  logic [31:0] scratch_q, readdata_q, rd_mux, be_mask;
  logic        rdv_q, irq_q, rx_rdy_q;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, rd_acc, rx_underflow;

  assign tx_full  = (tx_level_q == LW'(Depth));
  assign tx_empty = (tx_level_q == '0);
  assign rx_full  = (rx_level_q == LW'(Depth));
  assign rx_empty = (rx_level_q == '0);

  // Only a TX push into a full FIFO stalls; reads are never held off.
  assign avs_S1_waitrequest = avs_S1_write && (avs_S1_address == AddrTxData) && tx_full;

  assign rd_acc       = avs_S1_read && !avs_S1_waitrequest;
  assign tx_push      = avs_S1_write && (avs_S1_address == AddrTxData) && !tx_full &&
                        (|avs_S1_byteenable);
  assign tx_pop       = !tx_empty && aso_TX_ready;
  assign rx_push      = asi_RX_valid && asi_RX_ready;
  assign rx_pop       = rd_acc && (avs_S1_address == AddrRxData) && !rx_empty;
  assign rx_underflow = rd_acc && (avs_S1_address == AddrRxData) && rx_empty;

  assign aso_TX_valid         = !tx_empty;
  assign aso_TX_data          = tx_mem[tx_rptr_q];
  assign asi_RX_ready         = rx_rdy_q && !rx_full;
  assign avs_S1_readdata      = readdata_q;
  assign avs_S1_readdatavalid = rdv_q;
  assign ins_IRQ_irq          = irq_q;

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < 4; i++) begin
      be_mask[8*i +: 8] = {8{avs_S1_byteenable[i]}};
    end
  end

  // Status uses pre-update levels, so a same-cycle push/pop is not visible yet.
  always_comb begin
    rd_mux = '0;
    unique case (avs_S1_address)
      AddrStatus:  rd_mux = {22'd0, tx_full, rx_empty, 4'(tx_level_q), 4'(rx_level_q)};
      AddrPend:    rd_mux = {29'd0, pend_q};
      AddrMask:    rd_mux = {29'd0, mask_q};
      AddrRxData:  rd_mux = rx_empty ? 32'd0 : rx_mem[rx_rptr_q];
      AddrScratch: rd_mux = scratch_q;
      default:     rd_mux = '0;
    endcase
  end

  // A set event in the same cycle as a W1C clear wins.
  always_comb begin
    pend_set = {rx_underflow,
                (tx_level_q == LW'(1)) && tx_pop && !tx_push,
                rx_empty && rx_push};
    pend_clr = (avs_S1_write && (avs_S1_address == AddrPend) && avs_S1_byteenable[0]) ?
               avs_S1_writedata[2:0] : 3'd0;
    pend_d   = (pend_q & ~pend_clr) | pend_set;
  end

  // Storage arrays carry no reset; pointers and levels define their contents.
  always_ff @(posedge csi_MCLK_clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= avs_S1_writedata & be_mask;
    if (rx_push) rx_mem[rx_wptr_q] <= asi_RX_data;
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_level_q <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_level_q <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      scratch_q  <= '0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
      irq_q      <= 1'b0;
      rx_rdy_q   <= 1'b0;
    end else begin
      rx_rdy_q <= 1'b1;
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      tx_level_q <= tx_level_q + LW'(tx_push) - LW'(tx_pop);
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      rx_level_q <= rx_level_q + LW'(rx_push) - LW'(rx_pop);

      pend_q <= pend_d;
      irq_q  <= |(pend_q & mask_q);

      if (avs_S1_write && (avs_S1_address == AddrMask) && avs_S1_byteenable[0]) begin
        mask_q <= avs_S1_writedata[2:0];
      end
      if (avs_S1_write && (avs_S1_address == AddrScratch)) begin
        scratch_q <= (scratch_q & ~be_mask) | (avs_S1_writedata & be_mask);
      end

      rdv_q <= rd_acc;
      if (rd_acc) readdata_q <= rd_mux;
    end
  end

endmodule

// File: tb/tb_qsys_host_mailbox.sv
// Directed bench for qsys_host_mailbox: stimulus queues expected read data and TX stream
// words; negedge monitors pop and compare whenever the DUT presents them.
module tb_qsys_host_mailbox;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        rdv, waitreq;
  logic [31:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ready;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] exp_rd_data[$];
  int          exp_rd_cyc[$];
  logic [31:0] exp_tx[$];

  qsys_host_mailbox #(.FIFO_AW(3)) dut (
    .csi_MCLK_clk         (clk),
    .rsi_MRST_reset_n     (rst_n),
    .avs_S1_address       (address),
    .avs_S1_read          (read),
    .avs_S1_write         (write),
    .avs_S1_writedata     (writedata),
    .avs_S1_byteenable    (byteenable),
    .avs_S1_readdata      (readdata),
    .avs_S1_readdatavalid (rdv),
    .avs_S1_waitrequest   (waitreq),
    .aso_TX_data          (tx_data),
    .aso_TX_valid         (tx_valid),
    .aso_TX_ready         (tx_ready),
    .asi_RX_data          (rx_data),
    .asi_RX_valid         (rx_valid),
    .asi_RX_ready         (rx_ready),
    .ins_IRQ_irq          (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (rdv) begin
      if (exp_rd_data.size() == 0) begin
        check("rdv_unexpected", {31'd0, rdv}, 32'd0);
      end else begin
        check("readdata", readdata, exp_rd_data.pop_front());
        check("rdv_latency", cyc, exp_rd_cyc.pop_front());
      end
    end
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) check("tx_unexpected", tx_data, 32'hxxxx_xxxx);
      else check("tx_stream", tx_data, exp_tx.pop_front());
    end
  end

  // All tasks start and end at posedge+1.
  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    address = a;
    read    = 1'b1;
    exp_rd_data.push_back(exp);
    exp_rd_cyc.push_back(cyc + 1);
    @(posedge clk);
    #1 read = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    logic stalled;
    logic done;
    done       = 1'b0;
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      stalled = waitreq;
      @(posedge clk);
      done = !stalled;
    end
    #1 write = 1'b0;
    if (!done) check("write_timeout", {31'd0, waitreq}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tx_drain();
    for (int i = 0; i < 50 && exp_tx.size() != 0; i++) idle(1);
    check("tx_drain", exp_tx.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_readdata"}, readdata, 32'd0);
    check({tag, "_rdv"}, {31'd0, rdv}, 32'd0);
    check({tag, "_waitreq"}, {31'd0, waitreq}, 32'd0);
    check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_irq"}, {31'd0, irq}, 32'd0);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rx_ready_before_clk", {31'd0, rx_ready}, 32'd0);
    @(posedge clk);
    #1 check("rx_ready_first_clk", {31'd0, rx_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks,
             n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    byteenable = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    #3 check_reset_outputs("por");
    release_reset();

    // SCRATCH byte lanes and idle status.
    wr(3'd5, 32'hAABB_CCDD, 4'hF);
    wr(3'd5, 32'h1122_3344, 4'h5);
    rd(3'd5, 32'hAA22_CC44);
    rd(3'd0, 32'h0000_0100);

    // TX stall: eight words fill the FIFO, the ninth stalls until ready opens.
    for (int i = 1; i <= 9; i++) exp_tx.push_back(32'(i));
    for (int i = 1; i <= 8; i++) wr(3'd3, 32'(i), 4'hF);
    rd(3'd0, 32'h0000_0380);
    address = 3'd3; writedata = 32'd9; byteenable = 4'hF; write = 1'b1;
    @(negedge clk);
    check("waitreq_full", {31'd0, waitreq}, 32'd1);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("waitreq_released", {31'd0, waitreq}, 32'd0);
    @(posedge clk);
    #1 write = 1'b0;
    wait_tx_drain();

    // byteenable=0 push is dropped; partial lanes are zeroed.
    wr(3'd3, 32'h5555_5555, 4'h0);
    check("tx_be0_ignored", {31'd0, tx_valid}, 32'd0);
    exp_tx.push_back(32'h0000_BEEF);
    wr(3'd3, 32'hDEAD_BEEF, 4'h3);
    wait_tx_drain();
    rd(3'd1, 32'h2);
    wr(3'd1, 32'h7, 4'h1);
    rd(3'd1, 32'h0);

    // RX underflow and masked interrupt.
    rd(3'd4, 32'h0);
    rd(3'd1, 32'h4);
    wr(3'd2, 32'h4, 4'h1);
    idle(2);
    check("irq_underflow", {31'd0, irq}, 32'd1);
    wr(3'd1, 32'h4, 4'h1);
    idle(1);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // RX push coinciding with a W1C of PEND[0]: the set wins.
    rx_valid = 1'b1; rx_data = 32'h1234_5678;
    address = 3'd1; writedata = 32'h1; byteenable = 4'h1; write = 1'b1;
    @(negedge clk);
    check("rx_ready_idle", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0; write = 1'b0;
    rd(3'd1, 32'h1);
    rd(3'd0, 32'h0000_0001);
    rd(3'd4, 32'h1234_5678);
    rd(3'd0, 32'h0000_0100);

    // RX fill to full, pointer wrap, drain in order.
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1'b1;
      rx_data  = 32'hA000_0000 + 32'(i);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    check("rx_ready_full", {31'd0, rx_ready}, 32'd0);
    rd(3'd0, 32'h0000_0008);
    for (int i = 0; i < 8; i++) rd(3'd4, 32'hA000_0000 + 32'(i));
    rd(3'd0, 32'h0000_0100);

    // Reset one cycle after a read is accepted.
    tx_ready = 1'b0;
    wr(3'd3, 32'hCAFE_0001, 4'hF);
    wr(3'd3, 32'hCAFE_0002, 4'hF);
    wr(3'd2, 32'h1, 4'h1);
    idle(2);
    check("irq_pre_reset", {31'd0, irq}, 32'd1);
    check("tx_valid_pre_reset", {31'd0, tx_valid}, 32'd1);
    address = 3'd5; read = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0; read = 1'b0;
    #1 check_reset_outputs("mid_read");
    @(negedge clk);
    check("rdv_dropped", {31'd0, rdv}, 32'd0);
    release_reset();
    rd(3'd5, 32'h0);
    rd(3'd0, 32'h0000_0100);
    rd(3'd1, 32'h0);
    rd(3'd2, 32'h0);
    idle(2);
    check("tx_valid_post_reset", {31'd0, tx_valid}, 32'd0);
    check("rd_queue_empty", exp_rd_data.size(), 32'd0);
    check("tx_queue_empty", exp_tx.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
